// File: rtl/button_event_pkg.sv
// Shared definitions for button_event: FSM state encoding, event-kind codes
// for consumers that multiplex the event pulses onto a code bus, and helpers.
package button_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS1   = 3'd1,
    ST_GAP      = 3'd2,
    ST_LONG     = 3'd3,
    ST_WAIT_REL = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_SINGLE = 3'd1,
    EV_DOUBLE = 3'd2,
    EV_LONG   = 3'd3,
    EV_REPEAT = 3'd4
  } event_kind_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The pulses are mutually exclusive, so priority order here is irrelevant.
  function automatic event_kind_t encode_event(input logic single_press,
                                               input logic double_press,
                                               input logic long_press,
                                               input logic repeat_press);
    if (single_press) return EV_SINGLE;
    if (double_press) return EV_DOUBLE;
    if (long_press)   return EV_LONG;
    if (repeat_press) return EV_REPEAT;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/button_event_clk_div_hz.sv
// clk_div_hz: divides clk (CLK_HZ) down to a one-cycle dividedPulse at OUT_HZ
// while enable is high; the divider phase restarts on a synchronous rst.
module clk_div_hz #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned OUT_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic dividedPulse
);

  localparam int unsigned DIV      = (CLK_HZ / OUT_HZ >= 1) ? CLK_HZ / OUT_HZ : 1;
  localparam int unsigned DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      dividedPulse <= 1'b0;
    end else begin
      dividedPulse <= 1'b0;
      if (enable) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt      <= '0;
          dividedPulse <= 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/button_event.sv
// Gesture classifier: turns a debounced button level into single/double/long
// press pulses. Define BUTTON_EVENT_REPEAT_EN to add auto-repeat while held.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned TICK_HZ      = 1000,
  parameter int unsigned LONG_TICKS   = 800,
  parameter int unsigned DOUBLE_TICKS = 300,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic button_db,
  output logic single_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_press,
  output logic long_active
);

  localparam int unsigned CNT_MAX = max3(LONG_TICKS, DOUBLE_TICKS, REPEAT_TICKS);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

  logic             tick;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  clk_div_hz #(
    .OUT_HZ (TICK_HZ)
  ) inst_tickDiv (
    .clk          (clk),
    .rst          (rst),
    .enable       (1'b1),
    .dividedPulse (tick)
  );

  // Level checks come before timeout checks in every state so that a button
  // change always wins over a tick arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_WAIT_REL;
      cnt          <= '0;
      single_press <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      long_active  <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      repeat_press <= 1'b0;
`endif
    end else begin
      single_press <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      repeat_press <= 1'b0;
`endif
      if (tick && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (button_db) begin
            state <= ST_PRESS1;
            cnt   <= '0;
          end
        end

        ST_PRESS1: begin
          if (!button_db) begin
            state <= ST_GAP;
            cnt   <= '0;
          end else if (tick && cnt == LONG_LAST) begin
            state       <= ST_LONG;
            cnt         <= '0;
            long_press  <= 1'b1;
            long_active <= 1'b1;
          end
        end

        ST_GAP: begin
          if (button_db) begin
            state        <= ST_WAIT_REL;
            cnt          <= '0;
            double_press <= 1'b1;
          end else if (tick && cnt == DOUBLE_LAST) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            single_press <= 1'b1;
          end
        end

        ST_LONG: begin
          if (!button_db) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            long_active <= 1'b0;
          end
`ifdef BUTTON_EVENT_REPEAT_EN
          else if (tick && cnt == REPEAT_LAST) begin
            cnt          <= '0;
            repeat_press <= 1'b1;
          end
`endif
        end

        ST_WAIT_REL: begin
          if (!button_db) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end

        default: begin
          state       <= ST_WAIT_REL;
          cnt         <= '0;
          long_active <= 1'b0;
        end
      endcase
    end
  end

`ifndef BUTTON_EVENT_REPEAT_EN
  assign repeat_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: table of gesture shapes (in clk edges,
// aligned to the tick phase) plus hand-written reset sequences.
module tb_button_event;

  localparam int unsigned TICK_HZ  = 20_000_000;  // 100 MHz / 20 MHz: one tick every 5 clocks
  localparam int unsigned LONG_T   = 8;
  localparam int unsigned DOUBLE_T = 3;
  localparam int unsigned REPEAT_T = 2;
  localparam int          NVEC     = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button_db = 1'b0;
  logic single_press, double_press, long_press, repeat_press, long_active;

  button_event #(
    .TICK_HZ      (TICK_HZ),
    .LONG_TICKS   (LONG_T),
    .DOUBLE_TICKS (DOUBLE_T),
    .REPEAT_TICKS (REPEAT_T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button_db    (button_db),
    .single_press (single_press),
    .double_press (double_press),
    .long_press   (long_press),
    .repeat_press (repeat_press),
    .long_active  (long_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus times are edge offsets from t0, a tick-sampling edge.
  // first_at: edge offset at which the first single/double/long pulse is registered (-1: none).
  typedef struct packed {
    int p1; int g1; int p2; int tail;
    int n_single; int n_double; int n_long; int n_rep_en;
    int first_at; int la_cycles;
  } vec_t;

  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;
  int rel = 0;
  int t0 = 0;

  logic mon_en = 1'b0;
  int m_single, m_double, m_long, m_rep, m_first, m_la, m_multi;

  always @(negedge clk) begin
    if (mon_en) begin
      if (single_press) m_single++;
      if (double_press) m_double++;
      if (long_press)   m_long++;
      if (repeat_press) m_rep++;
      if (long_active)  m_la++;
      if ((single_press || double_press || long_press) && m_first < 0) m_first = cyc - t0;
      if ((32'(single_press) + 32'(double_press) + 32'(long_press) + 32'(repeat_press)) > 1) m_multi++;
    end
  end

  task automatic clear_mon();
    m_single = 0; m_double = 0; m_long = 0; m_rep = 0;
    m_first = -1; m_la = 0; m_multi = 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Divider restarts at reset release edge rel: ticks are sampled at rel+6, rel+11, ...
  task automatic align_tick();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!found) begin
        @(posedge clk);
        #1;
        found = ((cyc - rel) % 5 == 1) && ((cyc - rel) >= 6);
      end
    end
    if (!found) check("align_tick_timeout", 0, 1);
  endtask

  task automatic do_reset(input int n, input string name);
    rst = 1'b1;
    step(n);
    check(name, int'({single_press, double_press, long_press, repeat_press, long_active}), 0);
    rel = cyc;
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   exp_rep;
    v = vecs[idx];
    align_tick();
    t0 = cyc;
    clear_mon();
    mon_en = 1'b1;
    button_db = 1'b1;
    step(v.p1);
    button_db = 1'b0;
    step(v.g1);
    if (v.p2 != 0) begin
      button_db = 1'b1;
      step(v.p2);
      button_db = 1'b0;
    end
    step(v.tail);
    mon_en = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    exp_rep = v.n_rep_en;
`else
    exp_rep = 0;
`endif
    check($sformatf("vec%0d single_count", idx), m_single, v.n_single);
    check($sformatf("vec%0d double_count", idx), m_double, v.n_double);
    check($sformatf("vec%0d long_count", idx),   m_long,   v.n_long);
    check($sformatf("vec%0d repeat_count", idx), m_rep,    exp_rep);
    check($sformatf("vec%0d first_event_at", idx), m_first, v.first_at);
    check($sformatf("vec%0d long_active_cycles", idx), m_la, v.la_cycles);
    check($sformatf("vec%0d multi_hot", idx), m_multi, 0);
  endtask

  initial begin
    //          p1  g1  p2 tail  s  d  l  r  first la
    vecs[0] = '{10, 30,  0,  0,  1, 0, 0, 0, 25,   0};  // press 2 ticks: single 3 ticks after release
    vecs[1] = '{10,  5, 10, 20,  0, 1, 0, 0, 16,   0};  // double: one cycle after second press
    vecs[2] = '{60, 20,  0,  0,  0, 0, 1, 2, 40,  21};  // hold 12 ticks: long at 8th tick
    vecs[3] = '{65, 20,  0,  0,  0, 0, 1, 2, 40,  26};  // hold 13: repeats at ticks 10, 12
    vecs[4] = '{55, 20,  0,  0,  0, 0, 1, 1, 40,  16};  // hold 11: one repeat
    vecs[5] = '{39, 30,  0,  0,  1, 0, 0, 0, 55,   0};  // release on 8th tick: no long
    vecs[6] = '{10, 14, 10, 20,  0, 1, 0, 0, 25,   0};  // press on deciding gap tick: double
    vecs[7] = '{40, 20,  0,  0,  0, 0, 1, 0, 40,   1};  // release right after long tick
    vecs[8] = '{10, 15, 10, 30,  2, 0, 0, 0, 25,   0};  // second press just misses gap: two singles

    clear_mon();
    step(4);
    check("reset_outputs_initial", int'({single_press, double_press, long_press, repeat_press, long_active}), 0);
    rel = cyc;
    rst = 1'b0;
    step(3);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Reset mid-PRESS1 with the button held: nothing fires until release and a new press.
    align_tick();
    button_db = 1'b1;
    step(20);
    do_reset(3, "reset_outputs_mid_press1");
    t0 = cyc;
    clear_mon();
    mon_en = 1'b1;
    step(60);
    button_db = 1'b0;
    step(30);
    mon_en = 1'b0;
    check("post_reset_press1_events", m_single + m_double + m_long + m_rep, 0);
    check("post_reset_press1_long_active", m_la, 0);
    run_vec(0);

    // Reset while long_active is high.
    align_tick();
    button_db = 1'b1;
    step(45);
    check("long_active_before_reset", int'(long_active), 1);
    do_reset(2, "reset_outputs_mid_long");
    t0 = cyc;
    clear_mon();
    mon_en = 1'b1;
    step(60);
    button_db = 1'b0;
    step(30);
    mon_en = 1'b0;
    check("post_reset_long_events", m_single + m_double + m_long + m_rep, 0);
    check("post_reset_long_active", m_la, 0);
    run_vec(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
